// File: rtl/fns_seq_encoder_if.sv
// Bus bundle between the word producer and the FNS sequential encoder.
//
// Handshake rules, both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge. Ready may be asserted before valid and may depend
// on encoder state only, never on valid.
interface fns_seq_encoder_if #(
  parameter int DATA_W = 8,
  parameter int CODE_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CODE_W-1:0] err_mask;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_ovf;

  // Producer / consumer side (testbench or upstream logic).
  modport master (
    output in_valid, in_data, err_mask, out_ready,
    input  in_ready, out_valid, out_code, out_ovf
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data, err_mask, out_ready,
    output in_ready, out_valid, out_code, out_ovf
  );
endinterface

// File: rtl/fns_seq_encoder.sv
// Sequential binary-to-Fibonacci-numeral-system encoder.
// One transaction: latch word and fault mask, regenerate the per-wire
// Fibonacci weights one wire per cycle (faulty wires get weight 0 and push
// their weight to the next healthy wire), then greedy MSB-first conversion
// one wire per cycle, then hold the registered codeword until accepted.
module fns_seq_encoder #(
  parameter int DATA_W = 8,
  parameter int CODE_W = 12,
  parameter int WGT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fns_seq_encoder_if.slave bus,
  output logic             busy
);

  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WGEN = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [WGT_W-1:0]  rem;
  logic [WGT_W-1:0]  wa;
  logic [WGT_W-1:0]  wb;
  logic [WGT_W-1:0]  wt [CODE_W];
  logic [CODE_W-1:0] mask_r;
  logic [CODE_W-1:0] code_r;
  logic              ovf_r;

  logic              accept;
  logic              wire_ok;
  logic [WGT_W-1:0]  cap_nxt;
  logic              cap_ovf;
  logic              take_bit;

  // Shared decode terms used by both the FSM and the datapath.
  always_comb begin
    accept   = 1'b0;
    wire_ok  = 1'b0;
    cap_nxt  = '0;
    cap_ovf  = 1'b0;
    take_bit = 1'b0;
    accept   = (state == S_IDLE) && bus.in_valid;
    wire_ok  = !mask_r[idx];
    // Capacity is the running 'a' after the current wire has been processed;
    // only meaningful in the last weight-generation cycle.
    cap_nxt  = wire_ok ? wb : wa;
    cap_ovf  = (rem >= cap_nxt);
    take_bit = wire_ok && (rem >= wt[idx]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_WGEN;
      end
      S_WGEN: begin
        if (idx == IDX_LAST) begin
          state_nxt = cap_ovf ? S_DONE : S_CONV;
        end
      end
      S_CONV: begin
        if (idx == IDX_ZERO) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: word latch, weight generation and greedy conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      rem    <= '0;
      wa     <= '0;
      wb     <= '0;
      mask_r <= '0;
      code_r <= '0;
      ovf_r  <= 1'b0;
      for (int i = 0; i < CODE_W; i++) begin
        wt[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rem    <= WGT_W'(bus.in_data);
            mask_r <= bus.err_mask;
            idx    <= '0;
            wa     <= WGT_W'(1);
            wb     <= WGT_W'(2);
            code_r <= '0;
            ovf_r  <= 1'b0;
          end
        end
        S_WGEN: begin
          // Healthy wire takes the current Fibonacci weight and advances the
          // pair; a faulty wire takes 0 and leaves the pair for the next wire.
          if (wire_ok) begin
            wt[idx] <= wa;
            wa      <= wb;
            wb      <= wa + wb;
          end else begin
            wt[idx] <= '0;
          end
          if (idx == IDX_LAST) begin
            if (cap_ovf) begin
              ovf_r  <= 1'b1;
              code_r <= '0;
            end
            idx <= IDX_LAST;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_CONV: begin
          // Greedy step: largest remaining healthy weight first.
          if (take_bit) begin
            code_r[idx] <= 1'b1;
            rem         <= rem - wt[idx];
          end
          if (idx != IDX_ZERO) begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE: begin
          // Hold result until the consumer takes it.
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state and result registers.
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.out_code  = code_r;
    bus.out_ovf   = ovf_r;
    busy          = (state != S_IDLE);
  end

endmodule

// File: doc/fns_seq_encoder.md
Name: fns_seq_encoder

Overview:
- Sequential binary-to-Fibonacci-numeral-system (FNS) encoder that produces crosstalk-avoidance codewords for the bus wires.
- Sits directly upstream of the per-wire FNS adder/bypass slices.
- Applies the same per-wire fault handling: a faulty wire carries 0 and its Fibonacci weight moves up to the next healthy wire.
- Encoding is greedy, MSB-first, one wire per cycle. Weights are regenerated each transaction from the fault mask.

Parameters:
- DATA_W, 8, binary input width.
- CODE_W, 12, codeword width (bus wires).
- WGT_W, 16, weight/remainder width. Must hold g(CODE_W) and 2^DATA_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  encoder idle, can accept a word.
- in_data  input  DATA_W  binary value to encode.
- err_mask  input  CODE_W  per-wire fault flag, 1 = faulty wire. Sampled with in_data.
- out_valid  output  1  codeword valid.
- out_ready  input  1  consumer accepts codeword.
- out_code  output  CODE_W  FNS codeword, bit k drives wire k.
- out_ovf  output  1  value exceeds capacity of the healthy wires; out_code is 0.
- busy  output  1  state != IDLE.

Behaviour:
- Weight sequence: g0=1, g1=2, gk=g(k-1)+g(k-2), i.e. 1,2,3,5,8,13,21,34,55,89,144,233,...
- The j-th healthy wire (counting from wire 0) gets weight g(j). Faulty wires get weight 0.
- Capacity = g(H), where H = number of healthy wires.
- States: IDLE, WGEN, CONV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready (cycle T), latch in_data into the remainder and latch err_mask. Go to WGEN, idx=0.
- WGEN (CODE_W cycles, idx ascending 0..CODE_W-1):
  - Running pair (a,b) starts at (1,2).
  - Healthy wire: wt[idx]=a, then a<=b, b<=a+b.
  - Faulty wire: wt[idx]=0, pair unchanged.
  - After idx=CODE_W-1, cap=a.
  - If remainder >= cap: out_code=0, out_ovf=1, go to DONE (out_valid from T+CODE_W+1).
  - Else go to CONV, idx=CODE_W-1.
- CONV (CODE_W cycles, idx descending):
  - If err_mask[idx]=0 and remainder >= wt[idx]: set code bit idx, remainder -= wt[idx].
  - Otherwise code bit idx = 0.
  - After idx=0, go to DONE. Remainder must be 0 here (bench asserts).
- DONE: out_valid=1 from T+2*CODE_W+1. On out_ready, go to IDLE next cycle.
- Greedy Zeckendorf encoding guarantees no two adjacent healthy wires are both 1.
- Faulty wire bits in out_code are always 0.
- out_code and out_ovf are registered. They stay stable while out_valid && !out_ready.
- in_ready=0 outside IDLE. in_valid is ignored in WGEN/CONV/DONE. No acceptance in the same cycle as the out_valid handshake.
- All-faulty mask: cap=1. Data 0 gives code 0 with out_ovf=0; data >=1 gives out_ovf=1.
- Reset (async, any state):
  - state=IDLE, out_valid=0, out_code=0, out_ovf=0, busy=0, in_ready=1.
  - Remainder, weight table and idx cleared.
  - A transaction in flight is dropped with no output.

Test Plan:
- Defaults, mask 0x000, data 0 -> out_code 0x000, out_ovf 0, out_valid at T+25.
- Mask 0x000, data 255 -> 233+21+1 -> out_code 0x841, ovf 0. Data 100 -> 89+8+3 -> 0x214.
- Mask 0x001, data 100 -> weights shift up one wire -> out_code 0x428. Mask 0x001, data 255 -> cap 233 -> out_ovf 1, out_code 0, out_valid at T+13.
- Backpressure: out_ready=0 for 10 cycles after out_valid, new in_valid pulses -> out_code/out_ovf stable, in_ready 0, pulses ignored. Release -> IDLE next cycle.
- Mask 0xFFF, data 0 -> code 0, ovf 0. Same mask, data 1 -> ovf 1.
- rst_n low mid-CONV -> all outputs at reset values immediately. After release, a new word (data 7 -> 5+2 -> 0x00A) encodes correctly.
- Random sweep, all data 0..255 with random masks -> decode sum(wt) equals data when no ovf. No adjacent healthy 1s. Faulty wire bits are 0.
